muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_pkg.sv | 63 ++++++
 rtl/muldiv_ctrl_if.sv | 28 ++
 rtl/muldiv_ctrl_md_core.sv | 59 +++++
 rtl/muldiv_ctrl.sv | 127 ++++++++++++
 tb/tb_muldiv_ctrl.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - shared M-extension op codes, FSM states and result helpers
// Contents: md_code_e (funct3 encodings used by EX decode and the divider),
//           md_state_e (controller FSM states), md_special / md_finish helpers.
package muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_code_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } md_state_e;

    localparam logic [4:0]  LAST_ITER = 5'd31;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    function automatic logic md_is_div(input md_code_e code);
        return code[2];
    endfunction

    // Fixed results for divide-by-zero and signed INT_MIN / -1.
    function automatic logic [31:0] md_special(input md_code_e code,
                                               input logic [31:0] rs1,
                                               input logic div_zero);
        logic [31:0] res;
        if (div_zero)
            res = (code == MD_DIV || code == MD_DIVU) ? 32'hFFFF_FFFF : rs1;
        else
            res = (code == MD_DIV) ? INT_MIN : 32'h0000_0000;
        return res;
    endfunction

    // Applies sign correction to the magnitude result and selects the output word.
    // For divides acc holds {remainder, quotient}; for multiplies the product.
    function automatic logic [31:0] md_finish(input md_code_e code,
                                              input logic neg,
                                              input logic [63:0] acc);
        logic [63:0] prod;
        logic [31:0] quo;
        logic [31:0] rem;
        logic [31:0] res;
        prod = neg ? -acc : acc;
        quo  = neg ? -acc[31:0] : acc[31:0];
        rem  = neg ? -acc[63:32] : acc[63:32];
        case (code)
            MD_MUL:                       res = prod[31:0];
            MD_MULH, MD_MULHSU, MD_MULHU: res = prod[63:32];
            MD_DIV, MD_DIVU:              res = quo;
            default:                      res = rem;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - EX-stage <-> multiply/divide unit signal bundle
// master (EX side): drives cmd_md_ex, md_code_ex, rs1_sel, rs2_sel, jmp_purge_ma,
//                   rst_pipe, stall; receives md_stall, md_done, md_result.
// slave (muldiv_ctrl): the reverse.
interface muldiv_ctrl_if;
    import muldiv_ctrl_pkg::*;

    logic        cmd_md_ex;
    logic [2:0]  md_code_ex;
    logic [31:0] rs1_sel;
    logic [31:0] rs2_sel;
    logic        jmp_purge_ma;
    logic        rst_pipe;
    logic        stall;
    logic        md_stall;
    logic        md_done;
    logic [31:0] md_result;

    modport master (
        output cmd_md_ex, md_code_ex, rs1_sel, rs2_sel, jmp_purge_ma, rst_pipe, stall,
        input  md_stall, md_done, md_result
    );

    modport slave (
        input  cmd_md_ex, md_code_ex, rs1_sel, rs2_sel, jmp_purge_ma, rst_pipe, stall,
        output md_stall, md_done, md_result
    );
endinterface

// File: rtl/muldiv_ctrl_md_core.sv
// rtl/muldiv_ctrl_md_core.sv - 64-bit shift-add multiply / restoring divide datapath
// Ports: clk, rst; load (capture a_mag/b_mag), step (one iteration), is_div (mode),
//        a_mag (multiplier or dividend), b_mag (multiplicand or divisor),
//        acc_nxt (accumulator value after this cycle's update).
module md_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] a_mag,
    input  logic [31:0] b_mag,
    output logic [63:0] acc_nxt
);
    logic [63:0] acc_q, acc_d;
    logic [31:0] b_q, b_d;
    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic [32:0] trial;

    always_comb begin
        acc_d  = acc_q;
        b_d    = b_q;
        sum    = '0;
        rem_sh = '0;
        trial  = '0;
        if (load) begin
            acc_d = {32'h0, a_mag};
            b_d   = b_mag;
        end else if (step) begin
            if (is_div) begin
                // Remainder shifted left with the next dividend bit; can reach 33 bits.
                rem_sh = acc_q[63:31];
                trial  = rem_sh - {1'b0, b_q};
                if (rem_sh >= {1'b0, b_q})
                    acc_d = {trial[31:0], acc_q[30:0], 1'b1};
                else
                    acc_d = {rem_sh[31:0], acc_q[30:0], 1'b0};
            end else begin
                // Add multiplicand into the high half when the low bit is set, then shift right
                // keeping the carry.
                sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'h0);
                acc_d = {sum, acc_q[31:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
        end
    end

    assign acc_nxt = acc_d;
endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - RV32M multiply/divide controller with pipeline stall handshake
// Ports: clk, rst (sync, active-high); md (muldiv_ctrl_if.slave) carrying the EX command,
//        operands, purge/flush/stall inputs and md_stall/md_done/md_result outputs.
// Parameter EARLY_OUT: 1 = divide-by-zero and INT_MIN/-1 finish without iterating.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_ctrl_if.slave  md
);
    md_state_e   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    md_code_e    code_q, code_d;
    logic        neg_q, neg_d;
    logic        spec_q, spec_d;
    logic [31:0] spec_res_q, spec_res_d;
    logic [31:0] result_q, result_d;

    md_code_e    code_in;
    logic        start;
    logic        signed_a, signed_b, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        div_zero, div_ovf;
    logic        core_load, core_step;
    logic [63:0] acc_nxt;

    assign code_in  = md_code_e'(md.md_code_ex);
    assign start    = (state_q == S_IDLE) && md.cmd_md_ex && !md.jmp_purge_ma && !md.rst_pipe;
    assign signed_a = (code_in == MD_MULH) || (code_in == MD_MULHSU) ||
                      (code_in == MD_DIV)  || (code_in == MD_REM);
    assign signed_b = (code_in == MD_MULH) || (code_in == MD_DIV) || (code_in == MD_REM);
    assign a_neg    = signed_a && md.rs1_sel[31];
    assign b_neg    = signed_b && md.rs2_sel[31];
    assign a_mag    = a_neg ? -md.rs1_sel : md.rs1_sel;
    assign b_mag    = b_neg ? -md.rs2_sel : md.rs2_sel;
    assign div_zero = md_is_div(code_in) && (md.rs2_sel == 32'h0);
    assign div_ovf  = ((code_in == MD_DIV) || (code_in == MD_REM)) &&
                      (md.rs1_sel == INT_MIN) && (md.rs2_sel == 32'hFFFF_FFFF);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        neg_d      = neg_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        result_d   = result_q;
        core_load  = 1'b0;
        core_step  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    code_d     = code_in;
                    // Remainder takes the dividend's sign; everything else the XOR.
                    neg_d      = (code_in == MD_REM) ? a_neg : (a_neg ^ b_neg);
                    spec_d     = div_zero || div_ovf;
                    spec_res_d = md_special(code_in, md.rs1_sel, div_zero);
                    cnt_d      = 5'd0;
                    core_load  = 1'b1;
                    if ((div_zero || div_ovf) && EARLY_OUT) begin
                        state_d  = S_DONE;
                        result_d = md_special(code_in, md.rs1_sel, div_zero);
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                core_step = 1'b1;
                cnt_d     = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d  = S_DONE;
                    // acc_nxt already includes the final iteration.
                    result_d = spec_q ? spec_res_q : md_finish(code_q, neg_q, acc_nxt);
                end
            end
            S_DONE: begin
                if (!md.stall)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (md.rst_pipe) begin
            state_d   = S_IDLE;
            cnt_d     = 5'd0;
            core_step = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            code_q     <= MD_MUL;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= 32'h0;
            result_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            neg_q      <= neg_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            result_q   <= result_d;
        end
    end

    md_core u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (core_load),
        .step    (core_step),
        .is_div  (md_is_div(code_q)),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .acc_nxt (acc_nxt)
    );

    assign md.md_stall  = start || (state_q == S_CALC);
    assign md.md_done   = (state_q == S_DONE);
    assign md.md_result = result_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    muldiv_ctrl_if ifc ();

    muldiv_ctrl #(.EARLY_OUT(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .md  (ifc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op with cmd held while stalled; checks result, stalled cycles and
    // that md_done lasts exactly one cycle.
    task automatic run_op(input string tag, input logic [2:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_stalls);
        int  n_stall;
        bit  seen;
        n_stall = 0;
        seen    = 1'b0;
        @(negedge clk);
        ifc.cmd_md_ex  = 1'b1;
        ifc.md_code_ex = code;
        ifc.rs1_sel    = a;
        ifc.rs2_sel    = b;
        #1;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (ifc.md_done) begin
                seen = 1'b1;
            end else begin
                if (ifc.md_stall) n_stall++;
                @(negedge clk);
                #1;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_result"}, ifc.md_result, exp_res);
        check({tag, "_stalls"}, 32'(n_stall), 32'(exp_stalls));
        ifc.cmd_md_ex = 1'b0;
        @(negedge clk);
        #1;
        check({tag, "_done_drop"}, {31'h0, ifc.md_done}, 32'h0);
    endtask

    initial begin
        int  n_done;
        ifc.cmd_md_ex    = 1'b0;
        ifc.md_code_ex   = 3'd0;
        ifc.rs1_sel      = 32'h0;
        ifc.rs2_sel      = 32'h0;
        ifc.jmp_purge_ma = 1'b0;
        ifc.rst_pipe     = 1'b0;
        ifc.stall        = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", {31'h0, ifc.md_stall}, 32'h0);
        check("rst_done", {31'h0, ifc.md_done}, 32'h0);
        check("rst_result", ifc.md_result, 32'h0);
        rst = 1'b0;

        run_op("mul",     3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulh",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("div",     3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
        run_op("rem",     3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        run_op("divu0",   3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1);
        run_op("remu0",   3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1);
        run_op("div0",    3'd4, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1);
        run_op("divovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("removf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        run_op("divu",    3'd5, 32'd100,       32'd7,         32'd14,        33);

        // Abort at CALC count 10: start negedge, then 11 more negedges.
        @(negedge clk);
        ifc.cmd_md_ex  = 1'b1;
        ifc.md_code_ex = 3'd0;
        ifc.rs1_sel    = 32'd9;
        ifc.rs2_sel    = 32'd9;
        repeat (11) @(negedge clk);
        ifc.rst_pipe  = 1'b1;
        ifc.cmd_md_ex = 1'b0;
        @(negedge clk);
        #1;
        check("abort_stall", {31'h0, ifc.md_stall}, 32'h0);
        check("abort_done", {31'h0, ifc.md_done}, 32'h0);
        ifc.rst_pipe = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (ifc.md_done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        run_op("mul_after", 3'd0, 32'd3, 32'd4, 32'd12, 33);

        // rst_pipe together with a start: nothing begins.
        @(negedge clk);
        ifc.cmd_md_ex = 1'b1;
        ifc.rst_pipe  = 1'b1;
        #1;
        check("flush_start_stall", {31'h0, ifc.md_stall}, 32'h0);
        @(negedge clk);
        ifc.cmd_md_ex = 1'b0;
        ifc.rst_pipe  = 1'b0;
        #1;
        check("flush_start_idle", {30'h0, ifc.md_stall, ifc.md_done}, 32'h0);

        // Stall held for 3 cycles on DONE entry; cmd stays high to prove no restart.
        @(negedge clk);
        ifc.cmd_md_ex  = 1'b1;
        ifc.md_code_ex = 3'd5;
        ifc.rs1_sel    = 32'd100;
        ifc.rs2_sel    = 32'd7;
        #1;
        for (int i = 0; i < 100 && !ifc.md_done; i++) begin
            @(negedge clk);
            #1;
        end
        check("hold_entry_done", {31'h0, ifc.md_done}, 32'h1);
        ifc.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("hold_done", {31'h0, ifc.md_done}, 32'h1);
            check("hold_result", ifc.md_result, 32'd14);
            check("hold_no_stall", {31'h0, ifc.md_stall}, 32'h0);
        end
        ifc.stall     = 1'b0;
        ifc.cmd_md_ex = 1'b0;
        @(negedge clk);
        #1;
        check("hold_exit", {30'h0, ifc.md_stall, ifc.md_done}, 32'h0);

        // Reset in the middle of an operation.
        @(negedge clk);
        ifc.cmd_md_ex  = 1'b1;
        ifc.md_code_ex = 3'd0;
        ifc.rs1_sel    = 32'd5;
        ifc.rs2_sel    = 32'd6;
        repeat (5) @(negedge clk);
        rst           = 1'b1;
        ifc.cmd_md_ex = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_state", {30'h0, ifc.md_stall, ifc.md_done}, 32'h0);
        check("midrst_result", ifc.md_result, 32'h0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
